// File: rtl/morra_pkg.sv
// Shared types and helpers for the morra (rock-paper-scissors) referee.
//
// Contents:
//   move_t      player move encoding (NONE, SASSO, CARTA, FORBICE)
//   manche_t    per-round result code
//   partita_t   match result code
//   beats()     true when move a defeats move b
//   lead_width() width of the signed lead counter for a given saturation magnitude
package morra_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    SASSO   = 2'b01,
    CARTA   = 2'b10,
    FORBICE = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    ManNone = 2'b00,
    ManP1   = 2'b01,
    ManP2   = 2'b10,
    ManDraw = 2'b11
  } manche_t;

  typedef enum logic [1:0] {
    ParOngoing = 2'b00,
    ParP1      = 2'b01,
    ParP2      = 2'b10,
    ParDraw    = 2'b11
  } partita_t;

  // Rock beats scissors, scissors beats paper, paper beats rock.
  function automatic logic beats(move_t a, move_t b);
    logic res;
    case ({a, b})
      {SASSO, FORBICE}: res = 1'b1;
      {FORBICE, CARTA}: res = 1'b1;
      {CARTA, SASSO}:   res = 1'b1;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

  // Magnitude bits plus one sign bit.
  function automatic int unsigned lead_width(int unsigned lead_max);
    return $clog2(lead_max + 1) + 1;
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational judge for a single round.
//
// Ports:
//   p1, p2      moves of player 1 and player 2
//   blk1, blk2  moves each player is currently forbidden to repeat (NONE = no block)
//   valid       round counts (both moves present, neither player repeats a blocked move)
//   manche      round result; ManNone whenever the round is not valid
module morra_round_judge
  import morra_pkg::*;
(
  input  move_t   p1,
  input  move_t   p2,
  input  move_t   blk1,
  input  move_t   blk2,
  output logic    valid,
  output manche_t manche
);

  always_comb begin
    valid = (p1 != NONE) && (p2 != NONE) && (p1 != blk1) && (p2 != blk2);
    if (!valid) begin
      manche = ManNone;
    end else if (p1 == p2) begin
      manche = ManDraw;
    end else if (beats(p1, p2)) begin
      manche = ManP1;
    end else begin
      manche = ManP2;
    end
  end

endmodule

// File: rtl/morra_referee_param.sv
// Parametrised two-player morra referee.
//
// Tracks valid rounds, a saturating signed lead and per-player block registers
// (the winner of a round may not repeat the winning move next round). The match
// ends early once MIN_ROUNDS valid rounds are played and |lead| >= WIN_LEAD, or
// at max_rounds, which is captured as MIN_ROUNDS + {primo, secondo} during reset.
// Once decided, the match result is sticky until the next reset.
//
// Optional feature macro: MORRA_SCORE_EN adds per-player win counters.
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high reset; also captures the match configuration
//   primo    player-1 move / config bits [3:2] during reset
//   secondo  player-2 move / config bits [1:0] during reset
//   manche   registered round result (00 none, 01 P1, 10 P2, 11 draw)
//   partita  registered match result (00 ongoing, 01 P1, 10 P2, 11 draw)
//   rounds   valid rounds played
//   lead     signed lead, positive when P1 is ahead
//   wins1    (MORRA_SCORE_EN) P1 valid round wins
//   wins2    (MORRA_SCORE_EN) P2 valid round wins
module morra_referee_param
  import morra_pkg::*;
#(
  parameter int unsigned MIN_ROUNDS = 4,
  parameter int unsigned WIN_LEAD   = 2,
  parameter int unsigned LEAD_MAX   = 3,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [1:0]                            primo,
  input  logic [1:0]                            secondo,
  output logic [1:0]                            manche,
  output logic [1:0]                            partita,
  output logic [CNT_W-1:0]                      rounds,
  output logic signed [lead_width(LEAD_MAX)-1:0] lead
`ifdef MORRA_SCORE_EN
  ,
  output logic [CNT_W-1:0]                      wins1,
  output logic [CNT_W-1:0]                      wins2
`endif
);

  localparam int unsigned LW = lead_width(LEAD_MAX);

  localparam logic signed [LW-1:0] LeadMax = LW'(LEAD_MAX);
  localparam logic signed [LW-1:0] LeadMin = -LeadMax;
  localparam logic signed [LW-1:0] LeadOne = LW'(1);
  localparam logic signed [LW-1:0] WinLead = LW'(WIN_LEAD);
  localparam logic [CNT_W-1:0]     MinRnds = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0]     CntOne  = CNT_W'(1);

  move_t p1, p2;
  assign p1 = move_t'(primo);
  assign p2 = move_t'(secondo);

  manche_t                 manche_q, manche_d;
  partita_t                partita_q, partita_d;
  logic [CNT_W-1:0]        rounds_q, rounds_d;
  logic [CNT_W-1:0]        max_rounds_q;
  logic signed [LW-1:0]    lead_q, lead_d;
  move_t                   blk1_q, blk1_d, blk2_q, blk2_d;

  logic    round_valid;
  manche_t round_manche;

  morra_round_judge u_judge (
    .p1     (p1),
    .p2     (p2),
    .blk1   (blk1_q),
    .blk2   (blk2_q),
    .valid  (round_valid),
    .manche (round_manche)
  );

  // Rounds only advance while the match is open; once decided everything freezes.
  logic play;
  assign play = (partita_q == ParOngoing) && round_valid;

  always_comb begin
    manche_d  = ManNone;
    partita_d = partita_q;
    rounds_d  = rounds_q;
    lead_d    = lead_q;
    blk1_d    = blk1_q;
    blk2_d    = blk2_q;

    if (play) begin
      manche_d = round_manche;
      rounds_d = rounds_q + CntOne;
      case (round_manche)
        ManP1: begin
          lead_d = (lead_q == LeadMax) ? lead_q : lead_q + LeadOne;
          blk1_d = p1;
          blk2_d = NONE;
        end
        ManP2: begin
          lead_d = (lead_q == LeadMin) ? lead_q : lead_q - LeadOne;
          blk2_d = p2;
          blk1_d = NONE;
        end
        default: begin
          blk1_d = NONE;
          blk2_d = NONE;
        end
      endcase

      // Decision uses the post-update counters so it lands with the deciding round.
      if ((rounds_d >= MinRnds) && ((lead_d >= WinLead) || (lead_d <= -WinLead))) begin
        partita_d = lead_d[LW-1] ? ParP2 : ParP1;
      end else if (rounds_d == max_rounds_q) begin
        if (lead_d == '0) begin
          partita_d = ParDraw;
        end else begin
          partita_d = lead_d[LW-1] ? ParP2 : ParP1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      manche_q     <= ManNone;
      partita_q    <= ParOngoing;
      rounds_q     <= '0;
      lead_q       <= '0;
      blk1_q       <= NONE;
      blk2_q       <= NONE;
      max_rounds_q <= MinRnds + CNT_W'({primo, secondo});
    end else begin
      manche_q  <= manche_d;
      partita_q <= partita_d;
      rounds_q  <= rounds_d;
      lead_q    <= lead_d;
      blk1_q    <= blk1_d;
      blk2_q    <= blk2_d;
    end
  end

  assign manche  = manche_q;
  assign partita = partita_q;
  assign rounds  = rounds_q;
  assign lead    = lead_q;

`ifdef MORRA_SCORE_EN
  logic [CNT_W-1:0] wins1_q, wins2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wins1_q <= '0;
      wins2_q <= '0;
    end else if (play) begin
      if (round_manche == ManP1) wins1_q <= wins1_q + CntOne;
      if (round_manche == ManP2) wins2_q <= wins2_q + CntOne;
    end
  end

  assign wins1 = wins1_q;
  assign wins2 = wins2_q;
`else
  // Win counters compiled out.
`endif

endmodule
